// File: rtl/csr_bus_regfile_pkg.sv
// Shared constants, register map, masks and types for the HDC core CSR register bank.
package csr_bus_regfile_pkg;

    localparam int CsrDataWidth = 32;
    localparam int CsrAddrWidth = 32;
    localparam int NumCsrRegs   = 21;

    // Register addresses with special behaviour; everything else is plain RW.
    localparam int CoreSetAddr       = 0;
    localparam int AmPredictAddr     = 2;
    localparam int InstCtrlAddr      = 3;
    localparam int InstWriteDataAddr = 5;
    localparam int InstPcAddr        = 7;
    localparam int InstAtAddrAddr    = 8;

    // CORE_SET: bit0 start (never stored), bit1 live busy, bits 6..9 self-clearing.
    localparam logic [CsrDataWidth-1:0] CoreSetRoMask  = 32'h0000_0003;
    localparam logic [CsrDataWidth-1:0] CoreSetScMask  = 32'h0000_03C0;
    // INST_CTRL: bit0 write mode, bit2 self-clearing.
    localparam logic [CsrDataWidth-1:0] InstCtrlScMask = 32'h0000_0004;

    typedef enum logic {
        CSR_IDLE = 1'b0,
        CSR_RSP  = 1'b1
    } csr_state_e;

    typedef struct packed {
        logic [CsrDataWidth-1:0] data;
        logic                    valid;
    } csr_rsp_t;

    // Bits a host write can never store (hardware-owned or pulse-only).
    function automatic logic [CsrDataWidth-1:0] ro_mask(input int idx);
        case (idx)
            CoreSetAddr:                              return CoreSetRoMask;
            AmPredictAddr, InstPcAddr, InstAtAddrAddr: return '1;
            default:                                  return '0;
        endcase
    endfunction

    // Bits that hardware clears one cycle after they were written.
    function automatic logic [CsrDataWidth-1:0] sc_mask(input int idx);
        case (idx)
            CoreSetAddr:  return CoreSetScMask;
            InstCtrlAddr: return InstCtrlScMask;
            default:      return '0;
        endcase
    endfunction

endpackage

// File: rtl/csr_bus_regfile_reg_bank.sv
// Physical CSR storage: write enable, self-clearing bits and the read-only overlay.
module csr_bus_regfile_reg_bank
    import csr_bus_regfile_pkg::*;
(
    input  logic                                   clk_i,
    input  logic                                   rst_ni,
    input  logic                                   wr_en_i,
    input  logic [CsrAddrWidth-1:0]                wr_addr_i,
    input  logic [CsrDataWidth-1:0]                wr_data_i,
    input  logic                                   core_busy_i,
    input  logic [7:0]                             am_predict_i,
    input  logic                                   am_predict_valid_i,
    input  logic [CsrDataWidth-1:0]                inst_pc_i,
    input  logic [CsrDataWidth-1:0]                inst_at_addr_i,
    output logic [NumCsrRegs-1:0][CsrDataWidth-1:0] reg_set_o
);

    logic [NumCsrRegs-1:0][CsrDataWidth-1:0] regs_q;

    // Store writable bits; self-clearing bits drop after one cycle unless rewritten.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            regs_q <= '0;
        end else begin
            for (int i = 0; i < NumCsrRegs; i++) begin
                if (wr_en_i && (wr_addr_i == CsrAddrWidth'(i))) begin
                    regs_q[i] <= wr_data_i & ~ro_mask(i);
                end else begin
                    regs_q[i] <= regs_q[i] & ~sc_mask(i);
                end
            end
        end
    end

    // Present stored values with live status fields substituted in.
    always_comb begin
        reg_set_o                 = regs_q;
        reg_set_o[CoreSetAddr][1] = core_busy_i;
        reg_set_o[AmPredictAddr]  = {{(CsrDataWidth-9){1'b0}}, am_predict_valid_i, am_predict_i};
        reg_set_o[InstPcAddr]     = inst_pc_i;
        reg_set_o[InstAtAddrAddr] = inst_at_addr_i;
    end

endmodule

// File: rtl/csr_bus_regfile.sv
// CSR bus slave for the HDC core: request/response handshake FSM, command pulses, register bank.
//
// Handshake: a request transfers on a cycle where csr_req_valid_i && csr_req_ready_o;
// a response transfers on a cycle where csr_rsp_valid_o && csr_rsp_ready_i. Once raised,
// csr_rsp_valid_o and csr_rsp_data_o stay constant until the response transfers.
module csr_bus_regfile
    import csr_bus_regfile_pkg::*;
(
    input  logic                                   clk_i,
    input  logic                                   rst_ni,
    input  logic [CsrAddrWidth-1:0]                csr_req_addr_i,
    input  logic [CsrDataWidth-1:0]                csr_req_data_i,
    input  logic                                   csr_req_write_i,
    input  logic                                   csr_req_valid_i,
    output logic                                   csr_req_ready_o,
    output logic [CsrDataWidth-1:0]                csr_rsp_data_o,
    output logic                                   csr_rsp_valid_o,
    input  logic                                   csr_rsp_ready_i,
    output logic [NumCsrRegs-1:0][CsrDataWidth-1:0] csr_reg_set_o,
    output logic                                   start_core_o,
    output logic                                   inst_wr_valid_o,
    input  logic                                   core_busy_i,
    input  logic [7:0]                             am_predict_i,
    input  logic                                   am_predict_valid_i,
    output logic                                   am_predict_ready_o,
    input  logic [CsrDataWidth-1:0]                inst_pc_i,
    input  logic [CsrDataWidth-1:0]                inst_at_addr_i,
    output csr_state_e                             dbg_state_o
);

    csr_state_e state_q, state_d;
    csr_rsp_t   rsp_q;
    logic       accept;
    logic       start_q, inst_wr_q;
    logic       hit_core_set, hit_am_predict, hit_inst_wdata;
    logic [CsrDataWidth-1:0]                 rd_data;
    logic [NumCsrRegs-1:0][CsrDataWidth-1:0] reg_set;

    assign hit_core_set   = (csr_req_addr_i == CsrAddrWidth'(CoreSetAddr));
    assign hit_am_predict = (csr_req_addr_i == CsrAddrWidth'(AmPredictAddr));
    assign hit_inst_wdata = (csr_req_addr_i == CsrAddrWidth'(InstWriteDataAddr));

    csr_bus_regfile_reg_bank u_reg_bank (
        .clk_i              (clk_i),
        .rst_ni             (rst_ni),
        .wr_en_i            (accept && csr_req_write_i),
        .wr_addr_i          (csr_req_addr_i),
        .wr_data_i          (csr_req_data_i),
        .core_busy_i        (core_busy_i),
        .am_predict_i       (am_predict_i),
        .am_predict_valid_i (am_predict_valid_i),
        .inst_pc_i          (inst_pc_i),
        .inst_at_addr_i     (inst_at_addr_i),
        .reg_set_o          (reg_set)
    );

    // Read mux over the live register view; unmatched (out-of-range) addresses read 0.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NumCsrRegs; i++) begin
            if (csr_req_addr_i == CsrAddrWidth'(i)) begin
                rd_data = reg_set[i];
            end
        end
    end

    // Handshake state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= CSR_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and request acceptance: one request at a time, response must drain first.
    always_comb begin
        state_d         = state_q;
        csr_req_ready_o = 1'b0;
        accept          = 1'b0;
        case (state_q)
            CSR_IDLE: begin
                csr_req_ready_o = 1'b1;
                if (csr_req_valid_i) begin
                    accept  = 1'b1;
                    state_d = CSR_RSP;
                end
            end
            CSR_RSP: begin
                if (csr_rsp_ready_i) begin
                    state_d = CSR_IDLE;
                end
            end
            default: state_d = CSR_IDLE;
        endcase
    end

    // Registered response, captured in the accept cycle and held until taken.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp_q <= '0;
        end else if (accept) begin
            rsp_q.valid <= 1'b1;
            rsp_q.data  <= csr_req_write_i ? '0 : rd_data;
        end else if ((state_q == CSR_RSP) && csr_rsp_ready_i) begin
            rsp_q <= '0;
        end
    end

    // One-cycle command pulses, raised the cycle after the triggering write is accepted.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            start_q   <= 1'b0;
            inst_wr_q <= 1'b0;
        end else begin
            start_q   <= accept && csr_req_write_i && hit_core_set &&
                         csr_req_data_i[0] && !core_busy_i;
            inst_wr_q <= accept && csr_req_write_i && hit_inst_wdata &&
                         reg_set[InstCtrlAddr][0];
        end
    end

    // Prediction pop happens in the accept cycle of a read of the prediction register.
    assign am_predict_ready_o = accept && !csr_req_write_i && hit_am_predict && am_predict_valid_i;

    assign csr_rsp_data_o  = rsp_q.data;
    assign csr_rsp_valid_o = rsp_q.valid;
    assign csr_reg_set_o   = reg_set;
    assign start_core_o    = start_q;
    assign inst_wr_valid_o = inst_wr_q;
    assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_csr_bus_regfile.sv
// Self-checking bench for csr_bus_regfile: per-cycle behavioural model plus directed read expectations.
module tb_csr_bus_regfile;
    import csr_bus_regfile_pkg::*;

    // ---------------- clock / reset / DUT ----------------
    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [31:0] csr_req_addr_i;
    logic [31:0] csr_req_data_i;
    logic        csr_req_write_i;
    logic        csr_req_valid_i;
    logic        csr_req_ready_o;
    logic [31:0] csr_rsp_data_o;
    logic        csr_rsp_valid_o;
    logic        csr_rsp_ready_i;
    logic [20:0][31:0] csr_reg_set_o;
    logic        start_core_o;
    logic        inst_wr_valid_o;
    logic        core_busy_i;
    logic [7:0]  am_predict_i;
    logic        am_predict_valid_i;
    logic        am_predict_ready_o;
    logic [31:0] inst_pc_i;
    logic [31:0] inst_at_addr_i;
    csr_state_e  dbg_state_o;

    always #5 clk_i = ~clk_i;

    csr_bus_regfile dut (
        .clk_i              (clk_i),
        .rst_ni             (rst_ni),
        .csr_req_addr_i     (csr_req_addr_i),
        .csr_req_data_i     (csr_req_data_i),
        .csr_req_write_i    (csr_req_write_i),
        .csr_req_valid_i    (csr_req_valid_i),
        .csr_req_ready_o    (csr_req_ready_o),
        .csr_rsp_data_o     (csr_rsp_data_o),
        .csr_rsp_valid_o    (csr_rsp_valid_o),
        .csr_rsp_ready_i    (csr_rsp_ready_i),
        .csr_reg_set_o      (csr_reg_set_o),
        .start_core_o       (start_core_o),
        .inst_wr_valid_o    (inst_wr_valid_o),
        .core_busy_i        (core_busy_i),
        .am_predict_i       (am_predict_i),
        .am_predict_valid_i (am_predict_valid_i),
        .am_predict_ready_o (am_predict_ready_o),
        .inst_pc_i          (inst_pc_i),
        .inst_at_addr_i     (inst_at_addr_i),
        .dbg_state_o        (dbg_state_o)
    );

    // ---------------- bookkeeping ----------------
    int n_vec  = 0;
    int n_fail = 0;
    logic [31:0] exp_q[$];
    int start_cnt = 0, instwr_cnt = 0, pop_cnt = 0, sc_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_vec++;
        n_fail++;
        $display("FAIL timeout %s: DUT did not respond within cycle budget (t=%0t)", name, $time);
    endtask

    // ---------------- behavioural model ----------------
    // Persistent register contents, plus the one-cycle-visible "clear" bits of the last write.
    logic [31:0] m_regs[NumCsrRegs];
    logic [31:0] m_flash;
    int          m_flash_idx;
    bit          m_pending;
    logic [31:0] m_rsp;
    bit          m_start, m_instwr;

    function automatic logic [31:0] keep_bits(input int a, input logic [31:0] d);
        case (a)
            0:       return d & 32'hFFFF_FC3C;
            3:       return d & 32'hFFFF_FFFB;
            2, 7, 8: return 32'h0;
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] flash_bits(input int a, input logic [31:0] d);
        case (a)
            0:       return d & 32'h0000_03C0;
            3:       return d & 32'h0000_0004;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] vis(input int i);
        logic [31:0] v;
        v = m_regs[i];
        if (i == m_flash_idx) v = v | m_flash;
        case (i)
            0: v[1] = core_busy_i;
            2: v = {23'b0, am_predict_valid_i, am_predict_i};
            7: v = inst_pc_i;
            8: v = inst_at_addr_i;
            default: ;
        endcase
        return v;
    endfunction

    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NumCsrRegs; i++) m_regs[i] <= 32'h0;
            m_flash     <= 32'h0;
            m_flash_idx <= -1;
            m_pending   <= 1'b0;
            m_rsp       <= 32'h0;
            m_start     <= 1'b0;
            m_instwr    <= 1'b0;
        end else begin
            m_start  <= 1'b0;
            m_instwr <= 1'b0;
            m_flash  <= 32'h0;
            if (m_pending) begin
                if (csr_rsp_ready_i) m_pending <= 1'b0;
            end else if (csr_req_valid_i) begin
                m_pending <= 1'b1;
                if (csr_req_write_i) begin
                    m_rsp <= 32'h0;
                    if (csr_req_addr_i < NumCsrRegs) begin
                        m_regs[csr_req_addr_i[4:0]] <= keep_bits(int'(csr_req_addr_i[4:0]), csr_req_data_i);
                        m_flash     <= flash_bits(int'(csr_req_addr_i[4:0]), csr_req_data_i);
                        m_flash_idx <= int'(csr_req_addr_i[4:0]);
                    end
                    m_start  <= (csr_req_addr_i == 0) && csr_req_data_i[0] && !core_busy_i;
                    m_instwr <= (csr_req_addr_i == 5) && m_regs[3][0];
                end else begin
                    m_rsp <= (csr_req_addr_i < NumCsrRegs) ? vis(int'(csr_req_addr_i[4:0])) : 32'h0;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk_i) begin
        if (!rst_ni) begin
            check("rst_req_ready", 32'(csr_req_ready_o), 32'h1);
            check("rst_rsp_valid", 32'(csr_rsp_valid_o), 32'h0);
            check("rst_start", 32'(start_core_o), 32'h0);
            check("rst_inst_wr", 32'(inst_wr_valid_o), 32'h0);
        end else begin
            check("req_ready", 32'(csr_req_ready_o), 32'(!m_pending));
            check("rsp_valid", 32'(csr_rsp_valid_o), 32'(m_pending));
            if (m_pending) check("rsp_data", csr_rsp_data_o, m_rsp);
            check("state", 32'(dbg_state_o), m_pending ? 32'h1 : 32'h0);
            check("start_core", 32'(start_core_o), 32'(m_start));
            check("inst_wr_valid", 32'(inst_wr_valid_o), 32'(m_instwr));
            check("am_predict_ready", 32'(am_predict_ready_o),
                  32'(!m_pending && csr_req_valid_i && !csr_req_write_i &&
                      (csr_req_addr_i == 2) && am_predict_valid_i));
            for (int i = 0; i < NumCsrRegs; i++)
                check($sformatf("reg_set[%0d]", i), csr_reg_set_o[i], vis(i));
            // pulse / visibility counters for the directed expectations
            if (start_core_o) start_cnt++;
            if (inst_wr_valid_o) instwr_cnt++;
            if (am_predict_ready_o) pop_cnt++;
            if (csr_reg_set_o[3][2]) sc_cnt++;
            // scoreboard: directed expected response data
            if (csr_rsp_valid_o && csr_rsp_ready_i) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_fail++;
                    $display("FAIL rsp_unexpected: got 0x%08h with empty expected queue", csr_rsp_data_o);
                end else begin
                    check("rsp_expected", csr_rsp_data_o, exp_q.pop_front());
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_accept(input bit drop_valid);
        int t = 0;
        while (1) begin
            @(negedge clk_i);
            if (csr_req_ready_o) break;
            t++;
            if (t > 20) begin timeout("accept"); break; end
        end
        @(posedge clk_i);
        #1;
        if (drop_valid) csr_req_valid_i = 1'b0;
    endtask

    task automatic wait_rsp();
        int t = 0;
        while (1) begin
            @(negedge clk_i);
            if (csr_rsp_valid_o) break;
            t++;
            if (t > 20) begin timeout("response"); break; end
        end
        @(posedge clk_i);
        #1;
        csr_rsp_ready_i = 1'b0;
    endtask

    task automatic txn(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                       input logic [31:0] exp);
        exp_q.push_back(exp);
        csr_req_write_i = wr;
        csr_req_addr_i  = addr;
        csr_req_data_i  = data;
        csr_req_valid_i = 1'b1;
        wait_accept(1'b1);
        csr_rsp_ready_i = 1'b1;
        wait_rsp();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int c;
        rst_ni = 1'b1;
        csr_req_addr_i = '0; csr_req_data_i = '0; csr_req_write_i = 1'b0;
        csr_req_valid_i = 1'b0; csr_rsp_ready_i = 1'b0;
        core_busy_i = 1'b0; am_predict_i = '0; am_predict_valid_i = 1'b0;
        inst_pc_i = '0; inst_at_addr_i = '0;
        #2 rst_ni = 1'b0;
        repeat (3) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        @(negedge clk_i);
        check("post_rst_rsp_data", csr_rsp_data_o, 32'h0);
        check("post_rst_reg20", csr_reg_set_o[20], 32'h0);
        check("post_rst_reg0", csr_reg_set_o[0], 32'h0);
        @(posedge clk_i);
        #1;
        inst_pc_i      = 32'hCAFE_0010;
        inst_at_addr_i = 32'h1357_2468;

        // basic write / read-back
        txn(1, 20, 32'hA5A5_0003, 32'h0);
        txn(0, 20, 32'h0, 32'hA5A5_0003);

        // response back-pressure with a second request waiting
        txn(1, 1, 32'h1234_5678, 32'h0);
        exp_q.push_back(32'h1234_5678);
        exp_q.push_back(32'hA5A5_0003);
        csr_req_write_i = 1'b0; csr_req_addr_i = 1; csr_req_valid_i = 1'b1;
        wait_accept(1'b0);
        csr_req_addr_i = 20;
        repeat (5) begin
            @(negedge clk_i);
            check("hold_rsp_data", csr_rsp_data_o, 32'h1234_5678);
            check("hold_req_ready", 32'(csr_req_ready_o), 32'h0);
        end
        @(posedge clk_i);
        #1 csr_rsp_ready_i = 1'b1;
        wait_rsp();
        wait_accept(1'b1);
        csr_rsp_ready_i = 1'b1;
        wait_rsp();

        // start pulse, idle and busy
        c = start_cnt;
        txn(1, 0, 32'h1, 32'h0);
        txn(0, 0, 32'h0, 32'h0);
        check("start_pulses_idle", 32'(start_cnt - c), 32'h1);
        core_busy_i = 1'b1;
        txn(1, 0, 32'h1, 32'h0);
        txn(0, 0, 32'h0, 32'h2);
        check("start_pulses_busy", 32'(start_cnt - c), 32'h1);
        core_busy_i = 1'b0;
        txn(1, 0, 32'h0000_03F0, 32'h0);
        txn(0, 0, 32'h0, 32'h0000_0030);

        // prediction pop
        c = pop_cnt;
        am_predict_i = 8'h2C; am_predict_valid_i = 1'b1;
        txn(0, 2, 32'h0, 32'h0000_012C);
        check("pop_with_valid", 32'(pop_cnt - c), 32'h1);
        am_predict_valid_i = 1'b0;
        txn(0, 2, 32'h0, 32'h0000_002C);
        check("pop_without_valid", 32'(pop_cnt - c), 32'h1);

        // instruction write strobe and self-clear bit
        c = instwr_cnt;
        txn(1, 3, 32'h1, 32'h0);
        txn(1, 5, 32'h0000_DEAD, 32'h0);
        check("inst_wr_pulses", 32'(instwr_cnt - c), 32'h1);
        txn(0, 5, 32'h0, 32'h0000_DEAD);
        c = sc_cnt;
        txn(1, 3, 32'h4, 32'h0);
        check("inst_clr_cycles", 32'(sc_cnt - c), 32'h1);
        txn(0, 3, 32'h0, 32'h0);
        c = instwr_cnt;
        txn(1, 5, 32'h0000_BEEF, 32'h0);
        check("inst_wr_mode_off", 32'(instwr_cnt - c), 32'h0);
        txn(0, 5, 32'h0, 32'h0000_BEEF);

        // read-only status registers
        txn(0, 7, 32'h0, 32'hCAFE_0010);
        txn(1, 7, 32'hFFFF_FFFF, 32'h0);
        txn(0, 7, 32'h0, 32'hCAFE_0010);
        txn(0, 8, 32'h0, 32'h1357_2468);

        // out-of-range addresses
        txn(0, 25, 32'h0, 32'h0);
        txn(0, 21, 32'h0, 32'h0);
        txn(1, 25, 32'hFFFF_FFFF, 32'h0);
        txn(0, 32'h8000_0001, 32'h0, 32'h0);
        txn(0, 20, 32'hFFFF_FFFF, 32'hA5A5_0003);
        txn(0, 1, 32'h0, 32'h1234_5678);

        // reset while a response is pending
        csr_req_write_i = 1'b0; csr_req_addr_i = 20; csr_req_valid_i = 1'b1;
        wait_accept(1'b1);
        @(negedge clk_i);
        check("pre_abort_rsp_valid", 32'(csr_rsp_valid_o), 32'h1);
        #2 rst_ni = 1'b0;
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        @(negedge clk_i);
        check("abort_rsp_valid", 32'(csr_rsp_valid_o), 32'h0);
        check("abort_req_ready", 32'(csr_req_ready_o), 32'h1);
        @(posedge clk_i);
        #1;
        txn(0, 20, 32'h0, 32'h0);

        repeat (3) @(posedge clk_i);
        if (exp_q.size() != 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL rsp_missing: %0d expected responses never seen", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    // watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/csr_bus_regfile.md
Name: csr_bus_regfile

Overview:
- CSR bus slave that consumes the CSR address map (register addresses 0..20) and implements the physical control/status register bank of the HDC core.
- Host side: valid/ready request channel plus valid/ready response channel.
- Core side: flat register outputs, one-cycle command pulses, and read-only status capture.
- Sits between the SoC CSR interconnect and the core, instruction-memory and data-slicer control logic.

Parameters:
- CsrDataWidth, 32, register and bus data width.
- CsrAddrWidth, 32, request address width.
- NumCsrRegs, 21, implemented registers at addresses 0..NumCsrRegs-1.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- csr_req_addr_i  in  CsrAddrWidth  register address
- csr_req_data_i  in  CsrDataWidth  write data
- csr_req_write_i  in  1  1=write, 0=read
- csr_req_valid_i  in  1  request valid
- csr_req_ready_o  out  1  request accepted when valid&ready
- csr_rsp_data_o  out  CsrDataWidth  read data; 0 for writes
- csr_rsp_valid_o  out  1  response valid
- csr_rsp_ready_i  in  1  host takes response
- csr_reg_set_o  out  NumCsrRegs x CsrDataWidth  current register contents
- start_core_o  out  1  one-cycle start pulse
- inst_wr_valid_o  out  1  one-cycle instruction-write strobe
- core_busy_i  in  1  core busy status
- am_predict_i  in  8  associative-memory prediction
- am_predict_valid_i  in  1  prediction available
- am_predict_ready_o  out  1  pops prediction
- inst_pc_i  in  CsrDataWidth  current PC
- inst_at_addr_i  in  CsrDataWidth  instruction at the debug read address

Behaviour:
- Reset values:
  - all registers 0; csr_rsp_data_o 0; csr_rsp_valid_o 0.
  - all pulses 0; csr_req_ready_o 1.
- FSM, two states:
  - IDLE: csr_req_ready_o=1. On valid&ready, perform the access and go to RSP. The response is registered, so csr_rsp_valid_o rises the cycle after acceptance.
  - RSP: csr_req_ready_o=0. Hold data/valid stable until csr_rsp_ready_i=1, then return to IDLE.
  - Throughput: at most one transaction per 2 cycles.
- Out-of-range address (>= NumCsrRegs): read returns 0; write is ignored; a response is still issued.
- Read-only fields (writes ignored):
  - CORE_SET bit1 mirrors core_busy_i live.
  - Reg 2 = {23'b0, am_predict_valid_i, am_predict_i}.
  - Reg 7 = inst_pc_i.
  - Reg 8 = inst_at_addr_i.
- Read data is sampled in the accept cycle.
- Reading reg 2 while am_predict_valid_i=1 drives am_predict_ready_o=1 for exactly the accept cycle (pop). With no valid prediction, no pop occurs.
- Start bit (CORE_SET bit0):
  - Writing 1 while core_busy_i=0 produces start_core_o=1 on the cycle after acceptance.
  - The bit always reads 0.
  - Writing 1 while busy is dropped.
- Self-clearing clear bits: CORE_SET bits 6..9 and INST_CTRL bit2.
  - A written 1 is visible on csr_reg_set_o for exactly one cycle, then hardware clears it.
  - If a new write lands in the clearing cycle, the write wins.
- INST_WRITE_DATA (reg 5): a write while INST_CTRL bit0 (write mode)=1 pulses inst_wr_valid_o one cycle after acceptance. Data is stored regardless of mode.
- All other registers (1, 3 rest, 4, 6, 9..20) are plain RW; the full 32 bits are stored.
- Asynchronous reset mid-transaction aborts it: the response is discarded and the FSM returns to IDLE.
- csr_req_data_i is ignored on reads.

Decomposition:
- csr_addr_pkg additions:
  - NumCsrRegs constant.
  - Self-clear bit mask per register as localparams.
  - Typedef csr_rsp_t {data, valid}.
- One natural sub-module, csr_reg_bank: the register array with write-enable, self-clear and RO-mux logic.
- The top level keeps the handshake FSM and pulse generation.

Test Plan:
- Write 0xA5A5_0003 to reg 20, read reg 20 -> rsp 0xA5A5_0003; each rsp_valid is 1 cycle after acceptance; req_ready=0 during RSP.
- Hold csr_rsp_ready_i=0 for 5 cycles on a read of reg 1 -> rsp data/valid stable; a second request is not accepted until the handshake completes.
- Write 0x1 to reg 0 with core_busy_i=0 -> start_core_o pulses once; read reg 0 returns 0. Repeat with busy=1 -> no pulse; read returns 0x2.
- am_predict_i=0x2C, valid=1, read reg 2 -> rsp 0x12C, one am_predict_ready_o pulse. Read with valid=0 -> rsp 0x02C-free value 0x0 plus predict bits, no pop.
- Write 0x1 to reg 3, then 0xDEAD to reg 5 -> inst_wr_valid_o pulses once. Write 0x4 to reg 3 -> bit2 high for exactly one cycle, then reg 3 reads 0.
- Read reg 25 -> rsp 0. Write reg 25 -> all registers unchanged. Assert rst_ni low during RSP -> rsp_valid_o=0 and req_ready_o=1 after release.
